// File: rtl/spi_tx_frame.sv
// rtl/spi_tx_frame.sv - double-buffered multi-channel SPI frame transmitter
// Optional trailing even-parity bit: define SPI_TX_PARITY_EN.

module spi_tx_frame #(
   parameter int DATA_W        = 12,
   parameter int N_CH          = 1,
   parameter bit SHIFT_NEGEDGE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sclk,
   input  logic                     cs_n,
   input  logic                     load,
   input  logic [N_CH*DATA_W-1:0]   data_in,
   output logic                     serial_out,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     frame_abort,
   output logic                     overrun,
   output logic                     underrun
);

   localparam int FRAME_W = N_CH * DATA_W;
`ifdef SPI_TX_PARITY_EN
   localparam int N_BITS  = FRAME_W + 1;
`else
   localparam int N_BITS  = FRAME_W;
`endif
   localparam int   CNT_W     = $clog2(FRAME_W + 2);
   localparam logic SCLK_IDLE = !SHIFT_NEGEDGE;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t              r_state;
   logic [1:0]          r_sclk_sync;
   logic                r_sclk_d;
   logic [1:0]          r_cs_sync;
   logic                r_cs_d;
   logic [FRAME_W-1:0]  r_holding;
   logic                r_holding_valid;
   logic [N_BITS-1:0]   r_shreg;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic                r_frame_done;
   logic                r_frame_abort;
   logic                r_overrun;
   logic                r_underrun;

   logic                w_shift_edge;
   logic                w_cs_fall;
   logic                w_cs_rise;
   logic [N_BITS-1:0]   w_load_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= {2{SCLK_IDLE}};
         r_sclk_d    <= SCLK_IDLE;
         r_cs_sync   <= 2'b11;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], sclk};
         r_sclk_d    <= r_sclk_sync[1];
         r_cs_sync   <= {r_cs_sync[0], cs_n};
         r_cs_d      <= r_cs_sync[1];
      end
   end

   assign w_shift_edge = SHIFT_NEGEDGE ? (r_sclk_d & ~r_sclk_sync[1])
                                       : (~r_sclk_d & r_sclk_sync[1]);
   assign w_cs_fall    = r_cs_d & ~r_cs_sync[1];
   assign w_cs_rise    = ~r_cs_d & r_cs_sync[1];

   // Parity travels as the shift register LSB so it falls out after the data.
`ifdef SPI_TX_PARITY_EN
   assign w_load_val = {r_holding, ^r_holding};
`else
   assign w_load_val = r_holding;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_holding       <= '0;
         r_holding_valid <= 1'b0;
         r_shreg         <= '0;
         r_bit_cnt       <= '0;
         r_frame_done    <= 1'b0;
         r_frame_abort   <= 1'b0;
         r_overrun       <= 1'b0;
         r_underrun      <= 1'b0;
      end else begin
         r_frame_done  <= 1'b0;
         r_frame_abort <= 1'b0;
         r_overrun     <= 1'b0;
         r_underrun    <= 1'b0;
         if (load) begin
            r_holding       <= data_in;
            r_holding_valid <= 1'b1;
            r_overrun       <= r_holding_valid;
         end
         case (r_state)
            S_IDLE: begin
               if (w_cs_fall) begin
                  r_state    <= S_SHIFT;
                  r_shreg    <= w_load_val;
                  r_bit_cnt  <= '0;
                  r_underrun <= ~r_holding_valid;
                  if (!load) r_holding_valid <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (w_cs_rise) begin
                  r_frame_abort <= 1'b1;
                  r_state       <= S_IDLE;
               end else if (w_shift_edge) begin
                  r_shreg   <= r_shreg << 1;
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt == LAST_CNT) r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (w_cs_rise) begin
                  r_frame_done <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign serial_out  = (r_state == S_SHIFT) & r_shreg[N_BITS-1];
   assign busy        = (r_state != S_IDLE);
   assign frame_done  = r_frame_done;
   assign frame_abort = r_frame_abort;
   assign overrun     = r_overrun;
   assign underrun    = r_underrun;

endmodule

// File: tb/tb_spi_tx_frame.sv
// tb/tb_spi_tx_frame.sv - self-checking bench for spi_tx_frame (1- and 2-channel instances)

module tb_spi_tx_frame;

   localparam int N1 = 12;
   localparam int N2 = 24;
`ifdef SPI_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB1 = N1 + PAR;
   localparam int NB2 = N2 + PAR;

   logic clk = 1'b0;
   logic rst_n, sclk, cs_n, load;
   logic [11:0] d1;
   logic [23:0] d2;
   logic so1, busy1, done1, abort1, ov1, un1;
   logic so2, busy2, done2, abort2, ov2, un2;

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] m_hold1, m_hold2, f1, f2;
   logic        m_hv;
   int          k;

   always #5 clk = ~clk;

   spi_tx_frame #(.DATA_W(12), .N_CH(1), .SHIFT_NEGEDGE(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .load(load), .data_in(d1),
      .serial_out(so1), .busy(busy1), .frame_done(done1), .frame_abort(abort1),
      .overrun(ov1), .underrun(un1));

   spi_tx_frame #(.DATA_W(12), .N_CH(2), .SHIFT_NEGEDGE(1'b1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .load(load), .data_in(d2),
      .serial_out(so2), .busy(busy2), .frame_done(done2), .frame_abort(abort2),
      .overrun(ov2), .underrun(un2));

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Bit k of a transmitted frame: data MSB-first, optional parity, then zeros.
   function automatic logic exp_bit(logic [23:0] f, int w, int idx);
      if (idx < w) return f[w-1-idx];
      if (PAR == 1 && idx == w) return ^f;
      return 1'b0;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(logic [11:0] nd1, logic [23:0] nd2);
      @(negedge clk);
      load = 1'b1; d1 = nd1; d2 = nd2;
      @(negedge clk);
      load = 1'b0;
      check("overrun1", ov1, m_hv);
      check("overrun2", ov2, m_hv);
      m_hv = 1'b1; m_hold1 = {12'h000, nd1}; m_hold2 = nd2;
   endtask

   task automatic start_frame(bit lf, logic [11:0] nd1, logic [23:0] nd2);
      logic exp_un, exp_ov;
      f1 = m_hold1; f2 = m_hold2; exp_un = ~m_hv; exp_ov = m_hv; k = 0;
      @(negedge clk);
      cs_n = 1'b0;
      repeat (2) @(negedge clk);
      if (lf) begin load = 1'b1; d1 = nd1; d2 = nd2; end
      @(negedge clk);
      load = 1'b0;
      check("underrun1", un1, exp_un);
      check("underrun2", un2, exp_un);
      if (lf) begin
         check("overrun1 at cs_fall", ov1, exp_ov);
         check("overrun2 at cs_fall", ov2, exp_ov);
      end
      check("busy1 start", busy1, 1);
      check("busy2 start", busy2, 1);
      check("so1 bit0", so1, exp_bit(f1, N1, 0));
      check("so2 bit0", so2, exp_bit(f2, N2, 0));
      if (lf) begin m_hold1 = {12'h000, nd1}; m_hold2 = nd2; m_hv = 1'b1; end
      else m_hv = 1'b0;
   endtask

   task automatic shift_edges(int n);
      for (int e = 0; e < n; e++) begin
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
         repeat (5) @(negedge clk);
         k++;
         check($sformatf("so1 bit%0d", k), so1, exp_bit(f1, N1, k));
         check($sformatf("so2 bit%0d", k), so2, exp_bit(f2, N2, k));
         check("busy1 shifting", busy1, 1);
         check("busy2 shifting", busy2, 1);
      end
   endtask

   task automatic end_frame();
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      check("frame_done1", done1, k >= NB1);
      check("frame_abort1", abort1, k < NB1);
      check("frame_done2", done2, k >= NB2);
      check("frame_abort2", abort2, k < NB2);
      @(negedge clk);
      check("idle outputs1", {so1, busy1, done1, abort1}, 0);
      check("idle outputs2", {so2, busy2, done2, abort2}, 0);
   endtask

   initial begin
      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; load = 1'b0; d1 = '0; d2 = '0;
      m_hold1 = '0; m_hold2 = '0; m_hv = 1'b0; f1 = '0; f2 = '0; k = 0;
      repeat (3) @(negedge clk);
      check("reset outputs1", {so1, busy1, done1, abort1, ov1, un1}, 0);
      check("reset outputs2", {so2, busy2, done2, abort2, ov2, un2}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 12-bit frame: complete on the 1-channel unit, short on the 2-channel unit
      do_load(12'hA5C, {12'h123, 12'hABC});
      start_frame(1'b0, '0, '0);
      shift_edges(NB1);
      end_frame();

      // full 2-channel frame plus one surplus edge
      do_load(12'hA5C, {12'h123, 12'hABC});
      start_frame(1'b0, '0, '0);
      shift_edges(NB2 + 1);
      end_frame();

      // overrun on the second load, then underrun resends the same data
      do_load(12'h111, {12'h111, 12'h111});
      do_load(12'h222, {12'h222, 12'h222});
      start_frame(1'b0, '0, '0);
      shift_edges(NB2);
      end_frame();
      start_frame(1'b0, '0, '0);
      shift_edges(NB2);
      end_frame();

      // abort after 5 edges, next frame restarts from the MSB
      do_load(12'h5A3, 24'h3C_96A5);
      start_frame(1'b0, '0, '0);
      shift_edges(5);
      end_frame();
      do_load(12'hC3F, 24'hF0_0F55);
      start_frame(1'b0, '0, '0);
      shift_edges(NB2);
      end_frame();

      // load coinciding with cs_fall: old holding sent, new one kept valid
      do_load(12'h0F1, 24'h12_3456);
      start_frame(1'b1, 12'h9E7, 24'hAB_CDEF);
      shift_edges(NB2);
      end_frame();
      start_frame(1'b0, '0, '0);
      shift_edges(NB2);
      end_frame();

      // sclk activity with cs high is ignored
      for (int i = 0; i < 3; i++) begin
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
         repeat (5) @(negedge clk);
         check("idle sclk dut1", {so1, busy1, done1, abort1, un1}, 0);
         check("idle sclk dut2", {so2, busy2, done2, abort2, un2}, 0);
      end

      // reset mid-frame
      do_load(12'h7B4, 24'h76_5432);
      start_frame(1'b0, '0, '0);
      shift_edges(6);
      rst_n = 1'b0;
      #1;
      check("midreset outputs1", {so1, busy1, done1, abort1, ov1, un1}, 0);
      check("midreset outputs2", {so2, busy2, done2, abort2, ov2, un2}, 0);
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      check("held reset outputs1", {so1, busy1, done1, abort1, ov1, un1}, 0);
      rst_n = 1'b1;
      m_hold1 = '0; m_hold2 = '0; m_hv = 1'b0;
      start_frame(1'b0, '0, '0);
      shift_edges(NB2);
      end_frame();

      // parity-relevant pattern (three ones)
      do_load(12'h007, 24'h00_7007);
      start_frame(1'b0, '0, '0);
      shift_edges(NB1);
      end_frame();

      // randomized frames
      for (int r = 0; r < 8; r++) begin
         logic [11:0] rd1;
         logic [23:0] rd2;
         int          ne;
         bit          lf;
         if ($urandom_range(0, 1) == 1) do_load(12'($urandom), 24'($urandom));
         rd1 = 12'($urandom);
         rd2 = 24'($urandom);
         lf  = ($urandom_range(0, 3) == 0);
         ne  = $urandom_range(0, NB2 + 2);
         start_frame(lf, rd1, rd2);
         shift_edges(ne);
         end_frame();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
